// File: rtl/keypad_digit_entry.sv
// Keypad front end: synchronises and debounces raw key lines, strobes validn low once per clean press,
// and shifts each accepted digit into a BCD entry buffer.
//   state      | meaning
//   IDLE       | waiting for a one-hot key pattern
//   PRESS_DB   | candidate key must stay unchanged for DEBOUNCE_CYCLES samples
//   HELD       | key accepted; waiting for all keys released
//   RELEASE_DB | keypad must read all-zero for DEBOUNCE_CYCLES samples
module keypad_digit_entry #(
    parameter int NUM_KEYS        = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = 4
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              enablen,
    input  logic [NUM_KEYS-1:0]               keypad,
    input  logic                              clearn,
    output logic [3:0]                        digit,
    output logic                              validn,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic                              full
);

    localparam int DW  = 4 * NUM_DIGITS;
    localparam int CW  = $clog2(NUM_DIGITS + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t                state_q, state_d;
    logic [NUM_KEYS-1:0]   ks1_q, ks_q;
    logic [NUM_KEYS-1:0]   cand_q, cand_d;
    logic [DBW-1:0]        cnt_q, cnt_d;
    logic [3:0]            digit_q, digit_d;
    logic                  validn_q, validn_d;
    logic [DW-1:0]         digits_q, digits_d;
    logic [CW-1:0]         count_q, count_d;
    logic [4:0]            ones;
    logic                  ks_onehot;
    logic [3:0]            cand_code;
    logic                  push;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ks1_q    <= '0;
            ks_q     <= '0;
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            validn_q <= 1'b1;
            digits_q <= '0;
            count_q  <= '0;
        end else begin
            ks1_q    <= keypad;
            ks_q     <= ks1_q;
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            validn_q <= validn_d;
            digits_q <= digits_d;
            count_q  <= count_d;
        end
    end

    // keypad[0] is key 0; the remaining lines are numbered downward from the top bit.
    always_comb begin
        ones      = '0;
        cand_code = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            ones = ones + 5'(ks_q[k]);
            if (cand_q[k]) begin
                cand_code = (k == 0) ? 4'd0 : 4'(NUM_KEYS - k);
            end
        end
        ks_onehot = (ones == 5'd1);
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        validn_d = 1'b1;
        push     = 1'b0;
        if (enablen) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks_onehot) begin
                        cand_d  = ks_q;
                        cnt_d   = DBW'(1);
                        state_d = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (ks_q != cand_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d  = HELD;
                        digit_d  = cand_code;
                        validn_d = 1'b0;
                        push     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DBW'(1);
                    end
                end
                HELD: begin
                    if (ks_q == '0) begin
                        cnt_d   = DBW'(1);
                        state_d = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (ks_q != '0) begin
                        state_d = HELD;
                    end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + DBW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Clear wins over a same-edge push; a push into a full buffer is dropped.
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        if (!clearn) begin
            digits_d = '0;
            count_d  = '0;
        end else if (push && (count_q < CW'(NUM_DIGITS))) begin
            digits_d = (digits_q << 4) | DW'(cand_code);
            count_d  = count_q + CW'(1);
        end
    end

    assign digit  = digit_q;
    assign validn = validn_q;
    assign digits = digits_q;
    assign count  = count_q;
    assign full   = (count_q == CW'(NUM_DIGITS));

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry at default parameters; expected values are hand-derived.
module tb_keypad_digit_entry;

    logic        clock;
    logic        resetn;
    logic        enablen;
    logic [9:0]  keypad;
    logic        clearn;
    logic [3:0]  digit;
    logic        validn;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        full;

    int n_checks = 0;
    int n_err    = 0;
    logic prev_low = 1'b0;

    keypad_digit_entry #(.NUM_KEYS(10), .DEBOUNCE_CYCLES(4), .NUM_DIGITS(4)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .enablen (enablen),
        .keypad  (keypad),
        .clearn  (clearn),
        .digit   (digit),
        .validn  (validn),
        .digits  (digits),
        .count   (count),
        .full    (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // validn must never be low on two consecutive cycles
    always @(negedge clock) begin
        if (prev_low) check_val("no_double_strobe", {31'd0, validn}, 32'd1);
        prev_low = (validn === 1'b0);
    end

    function automatic logic [9:0] key_of(input int c);
        logic [9:0] k;
        k = '0;
        if (c == 0) k[0] = 1'b1;
        else k[10 - c] = 1'b1;
        return k;
    endfunction

    // Apply k at a negedge, then observe n following negedges (one per rising edge).
    task automatic hold_watch(input logic [9:0] k, input int n, output int first, output int lows);
        first = 0;
        lows  = 0;
        keypad = k;
        for (int e = 1; e <= n; e++) begin
            @(negedge clock);
            if (validn === 1'b0) begin
                lows++;
                if (first == 0) first = e;
            end
        end
    endtask

    task automatic press(input int c, input string tag);
        int f, l;
        hold_watch(key_of(c), 10, f, l);
        check_val({tag, "_strobes"}, l, 1);
        check_val({tag, "_digit"}, {28'd0, digit}, c);
        hold_watch('0, 8, f, l);
    endtask

    task automatic pulse_clear();
        clearn = 1'b0;
        @(negedge clock);
        clearn = 1'b1;
    endtask

    initial begin
        int f, l, tl;
        resetn  = 1'b0;
        enablen = 1'b0;
        keypad  = '0;
        clearn  = 1'b1;
        repeat (3) @(negedge clock);
        check_val("rst_validn", {31'd0, validn}, 1);
        check_val("rst_digit",  {28'd0, digit}, 0);
        check_val("rst_digits", {16'd0, digits}, 0);
        check_val("rst_count",  {29'd0, count}, 0);
        check_val("rst_full",   {31'd0, full}, 0);
        resetn = 1'b1;
        @(negedge clock);

        // 1: key 5 held 20 cycles
        hold_watch(10'b0000100000, 20, f, l);
        check_val("t1_first_edge", f, 6);
        check_val("t1_strobes", l, 1);
        check_val("t1_digit",  {28'd0, digit}, 5);
        check_val("t1_digits", {16'd0, digits}, 16'h0005);
        check_val("t1_count",  {29'd0, count}, 1);
        hold_watch('0, 8, f, l);
        check_val("t1_release_quiet", l, 0);

        // 2: bouncing key 7, then stable
        tl = 0;
        for (int i = 0; i < 3; i++) begin
            hold_watch(10'b0000001000, 2, f, l); tl += l;
            hold_watch('0, 2, f, l);             tl += l;
        end
        check_val("t2_bounce_quiet", tl, 0);
        hold_watch(10'b0000001000, 12, f, l);
        check_val("t2_first_edge", f, 6);
        check_val("t2_strobes", l, 1);
        check_val("t2_digit", {28'd0, digit}, 7);
        check_val("t2_digits", {16'd0, digits}, 16'h0057);
        hold_watch('0, 8, f, l);

        // 3: two keys together, then one dropped
        hold_watch(10'b1000000100, 10, f, l);
        check_val("t3_multi_quiet", l, 0);
        check_val("t3_multi_count", {29'd0, count}, 2);
        hold_watch(10'b1000000000, 10, f, l);
        check_val("t3_first_edge", f, 6);
        check_val("t3_strobes", l, 1);
        check_val("t3_digit", {28'd0, digit}, 1);
        check_val("t3_digits", {16'd0, digits}, 16'h0571);
        hold_watch('0, 8, f, l);

        // 4: fill and overflow
        pulse_clear();
        check_val("t4_clr_digits", {16'd0, digits}, 0);
        check_val("t4_clr_count",  {29'd0, count}, 0);
        press(1, "t4_k1");
        press(2, "t4_k2");
        press(3, "t4_k3");
        check_val("t4_not_full", {31'd0, full}, 0);
        press(4, "t4_k4");
        check_val("t4_digits4", {16'd0, digits}, 16'h1234);
        check_val("t4_full4",   {31'd0, full}, 1);
        press(5, "t4_k5");
        check_val("t4_digits5", {16'd0, digits}, 16'h1234);
        check_val("t4_count5",  {29'd0, count}, 4);
        press(0, "t4_k0_full");
        check_val("t4_digits_k0", {16'd0, digits}, 16'h1234);

        // 5: clear on the same edge as a push of 9
        pulse_clear();
        press(3, "t5_k3");
        check_val("t5_pre_count", {29'd0, count}, 1);
        keypad = key_of(9);
        repeat (5) @(negedge clock);
        check_val("t5_pre_validn", {31'd0, validn}, 1);
        clearn = 1'b0;
        @(negedge clock);
        clearn = 1'b1;
        check_val("t5_validn", {31'd0, validn}, 0);
        check_val("t5_digit",  {28'd0, digit}, 9);
        check_val("t5_digits", {16'd0, digits}, 0);
        check_val("t5_count",  {29'd0, count}, 0);
        hold_watch(key_of(9), 4, f, l);
        hold_watch('0, 8, f, l);

        // enable gating: disabled press ignored, re-enable needs a fresh debounce
        enablen = 1'b1;
        hold_watch(key_of(2), 10, f, l);
        check_val("en_quiet", l, 0);
        check_val("en_count", {29'd0, count}, 0);
        check_val("en_digit_kept", {28'd0, digit}, 9);
        enablen = 1'b0;
        hold_watch(key_of(2), 10, f, l);
        check_val("en_first_edge", f, 4);
        check_val("en_strobes", l, 1);
        check_val("en_digits", {16'd0, digits}, 16'h0002);
        hold_watch('0, 8, f, l);

        // 6: reset while HELD on key 6
        hold_watch(key_of(6), 10, f, l);
        check_val("t6_strobes", l, 1);
        check_val("t6_held_digits", {16'd0, digits}, 16'h0026);
        resetn = 1'b0;
        #1;
        check_val("t6_rst_digit",  {28'd0, digit}, 0);
        check_val("t6_rst_digits", {16'd0, digits}, 0);
        check_val("t6_rst_count",  {29'd0, count}, 0);
        check_val("t6_rst_validn", {31'd0, validn}, 1);
        @(negedge clock);
        resetn = 1'b1;
        hold_watch(key_of(6), 12, f, l);
        check_val("t6_first_edge", f, 6);
        check_val("t6_strobes2", l, 1);
        check_val("t6_digit",  {28'd0, digit}, 6);
        check_val("t6_digits", {16'd0, digits}, 16'h0006);
        check_val("t6_count",  {29'd0, count}, 1);
        hold_watch('0, 8, f, l);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
